// File: rtl/conv1_out_streamer.sv
// -----------------------------------------------------------------------------
// conv1_out_streamer
//
// Drains the conv1 result buffer as a valid/ready word stream. One start pulse
// walks every word of the buffer in channel-outer, row, column-inner order.
// Each word goes out tagged with its (channel, row, column) indices, and the
// final word also carries out_last.
//
// Parameters:
//   COUT, H_OUT, W_OUT  output volume dimensions
//   DW                  signed result word width
//   AW                  result-buffer address width
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   start               one-cycle drain request (ignored unless idle)
//   busy                high while a drain is in progress
//   done                one-cycle pulse the cycle after the final handshake
//   rd_en, rd_addr      result-buffer read strobe and word address
//   rd_data             buffer data, returned one cycle after rd_en
//   out_valid/ready     stream handshake
//   out_data, out_last  stream word and final-word marker
//   out_ch/row/col      indices of the word on out_data
//
// Optional feature: define CONV1_STREAM_RELU_EN to replace negative words with
// zero before they enter the output FIFO. Without it, words pass unchanged.
// -----------------------------------------------------------------------------
module conv1_out_streamer #(
  parameter int COUT  = 64,
  parameter int H_OUT = 56,
  parameter int W_OUT = 56,
  parameter int DW    = 32,
  parameter int AW    = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [6:0]    out_ch,
  output logic [5:0]    out_row,
  output logic [5:0]    out_col
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic          last;
    logic [6:0]    ch;
    logic [5:0]    row;
    logic [5:0]    col;
    logic [DW-1:0] data;
  } entry_t;

  localparam logic [6:0] C_MAX = 7'(COUT - 1);
  localparam logic [5:0] H_MAX = 6'(H_OUT - 1);
  localparam logic [5:0] W_MAX = 6'(W_OUT - 1);

  state_t        state, state_next;

  logic [6:0]    c_cnt;
  logic [5:0]    h_cnt, w_cnt;
  logic [AW-1:0] addr_cnt;

  logic          pend;
  logic          pend_last;
  logic [6:0]    pend_ch;
  logic [5:0]    pend_row, pend_col;

  entry_t        fifo [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;

  entry_t        head, push_entry;
  logic [DW-1:0] load_data;
  logic          fifo_valid, pop, credit_ok, issue, issue_last;

  assign head       = fifo[rd_ptr];
  assign fifo_valid = (count != 2'd0);
  assign pop        = fifo_valid & out_ready & ~rst;
  assign issue_last = (c_cnt == C_MAX) && (h_cnt == H_MAX) && (w_cnt == W_MAX);

  // A new read may go out when the FIFO can still hold it on arrival. The word
  // popped this cycle frees its slot in time, which is what allows a new read
  // every cycle while the consumer keeps out_ready high.
  assign credit_ok = (({1'b0, count} - {2'b0, pop} + {2'b0, pend}) < 3'd2);

  // The first read goes out in the start cycle itself so that the first word
  // is already in the FIFO two cycles after start.
  assign issue = ~rst & (((state == IDLE) & start) | ((state == RUN) & credit_ok));

`ifdef CONV1_STREAM_RELU_EN
  assign load_data = rd_data[DW-1] ? '0 : rd_data;
`else
  assign load_data = rd_data;
`endif

  assign push_entry = {pend_last, pend_ch, pend_row, pend_col, load_data};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and outputs. Every output is forced low during reset so
  // the reset cycle itself shows a quiet interface.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = issue;
    rd_addr    = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    out_ch     = '0;
    out_row    = '0;
    out_col    = '0;

    case (state)
      IDLE:    if (issue) state_next = issue_last ? FLUSH : RUN;
      RUN:     if (issue && issue_last) state_next = FLUSH;
      FLUSH:   if (pop && head.last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (issue) rd_addr = addr_cnt;
    if (!rst) begin
      busy = (state == RUN) || (state == FLUSH);
      done = (state == DONE);
    end
    if (fifo_valid && !rst) begin
      out_valid = 1'b1;
      out_data  = head.data;
      out_last  = head.last;
      out_ch    = head.ch;
      out_row   = head.row;
      out_col   = head.col;
    end
  end

  // Address and index counters. They advance once per issued read and wrap
  // back to zero after the last word, so an idle streamer always starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
      c_cnt    <= '0;
      h_cnt    <= '0;
      w_cnt    <= '0;
    end else if (issue) begin
      addr_cnt <= issue_last ? '0 : addr_cnt + 1'b1;
      if (w_cnt == W_MAX) begin
        w_cnt <= '0;
        if (h_cnt == H_MAX) begin
          h_cnt <= '0;
          c_cnt <= (c_cnt == C_MAX) ? '0 : c_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end else begin
        w_cnt <= w_cnt + 1'b1;
      end
    end
  end

  // In-flight read tracker: the indices travel alongside the read so they can
  // be paired with the data when it returns a cycle later. Reset drops the
  // pending read, so an aborted drain never writes into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pend_ch   <= '0;
      pend_row  <= '0;
      pend_col  <= '0;
    end else begin
      pend      <= issue;
      pend_last <= issue_last;
      pend_ch   <= c_cnt;
      pend_row  <= h_cnt;
      pend_col  <= w_cnt;
    end
  end

  // Two-entry output FIFO. The credit check keeps returning reads from ever
  // finding it full, so every returned word is written without a full test.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (pend) begin
        fifo[wr_ptr] <= push_entry;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, pend} - {1'b0, pop};
    end
  end

endmodule
